// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame scheduler for the drawing processor command bus.
// Each pass runs CLEAR, NOTES, DIGIT1, DIGIT2, MARKS, DONE and then parks on the no-op command.
module draw_sequencer #(
    parameter int CLEAR_CYCLES = 3240,
    parameter int NOTE_CYCLES  = 16,
    parameter int DIGIT_CYCLES = 35,
    parameter int MARK_CYCLES  = 16,
    parameter int CNT_W        = 12
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [14:0] note_mask,
    output logic [4:0]  command,
    output logic        plot,
    output logic [3:0]  note_index,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_NOTES, S_DIGIT1, S_DIGIT2, S_MARKS, S_DONE
    } state_e;

    localparam logic [4:0] CMD_NOP    = 5'b10110;
    localparam logic [4:0] CMD_CLEAR  = 5'b10100;
    localparam logic [4:0] CMD_DIGIT1 = 5'b10001;
    localparam logic [4:0] CMD_DIGIT2 = 5'b10010;
    localparam logic [4:0] CMD_MARK0  = 5'b10111;
    localparam logic [4:0] CMD_MARK1  = 5'b11000;
    localparam logic [4:0] CMD_MARK2  = 5'b11001;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [14:0]      mask_q, mask_d;
    logic [1:0]       mark_q, mark_d;
    logic             pend_q, pend_d;
    logic             plot_q, plot_d;

    logic [3:0]       low_idx;
    logic [14:0]      mask_rest;
    logic [CNT_W-1:0] last_cnt;
    logic             seg_end;
    logic             drawing;

    // Lowest set bit of the latched mask: the next note to draw.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 4'(i);
        end
    end

    assign mask_rest = mask_q & ~(15'd1 << low_idx);
    assign drawing   = (state_q inside {S_CLEAR, S_NOTES, S_DIGIT1, S_DIGIT2, S_MARKS});

    always_comb begin
        last_cnt = '0;
        case (state_q)
            S_CLEAR:            last_cnt = CNT_W'(CLEAR_CYCLES - 1);
            S_NOTES:            last_cnt = CNT_W'(NOTE_CYCLES - 1);
            S_DIGIT1, S_DIGIT2: last_cnt = CNT_W'(DIGIT_CYCLES - 1);
            S_MARKS:            last_cnt = CNT_W'(MARK_CYCLES - 1);
            default:            last_cnt = '0;
        endcase
    end

    assign seg_end = (cnt_q == last_cnt);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            mark_q  <= '0;
            pend_q  <= 1'b0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            mark_q  <= mark_d;
            pend_q  <= pend_d;
            plot_q  <= plot_d;
        end
    end

    // NOTE: every variable gets a hold default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        mark_d  = mark_q;
        pend_d  = pend_q | frame_tick;
        plot_d  = enable & drawing;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_tick || pend_q) begin
                        mask_d  = note_mask;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_CLEAR;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: begin
                    cnt_d = cnt_q + 1'b1;
                    if (seg_end) begin
                        cnt_d = '0;
                        case (state_q)
                            S_CLEAR:  state_d = (mask_q != '0) ? S_NOTES : S_DIGIT1;
                            S_NOTES: begin
                                mask_d = mask_rest;
                                if (mask_rest == '0) state_d = S_DIGIT1;
                            end
                            S_DIGIT1: state_d = S_DIGIT2;
                            S_DIGIT2: begin
                                state_d = S_MARKS;
                                mark_d  = 2'd0;
                            end
                            S_MARKS: begin
                                if (mark_q == 2'd2) state_d = S_DONE;
                                else                mark_d  = mark_q + 2'd1;
                            end
                            default: state_d = state_q;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        command    = CMD_NOP;
        note_index = 4'hF;
        case (state_q)
            S_CLEAR:  command = CMD_CLEAR;
            S_NOTES: begin
                command    = 5'd2 + {1'b0, low_idx};
                note_index = low_idx;
            end
            S_DIGIT1: command = CMD_DIGIT1;
            S_DIGIT2: command = CMD_DIGIT2;
            S_MARKS: begin
                case (mark_q)
                    2'd0:    command = CMD_MARK0;
                    2'd1:    command = CMD_MARK1;
                    default: command = CMD_MARK2;
                endcase
            end
            default:  command = CMD_NOP;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign plot       = plot_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: randomized scoreboard bench; expected command segments and
// pass lengths are queued at each frame request and popped by a monitor.
module tb_draw_sequencer;

    localparam logic [4:0] NOP = 5'b10110;
    localparam logic [4:0] CLR = 5'b10100;
    localparam logic [4:0] D1  = 5'b10001;
    localparam logic [4:0] D2  = 5'b10010;
    localparam logic [4:0] M0  = 5'b10111;
    localparam logic [4:0] M1  = 5'b11000;
    localparam logic [4:0] M2  = 5'b11001;

    typedef struct {
        logic [4:0] cmd;
        logic [3:0] idx;
        int         len;
    } seg_t;

    logic        CLK = 1'b0;
    logic        reset, enable, frame_tick;
    logic [14:0] note_mask;
    logic [4:0]  command;
    logic        plot;
    logic [3:0]  note_index;
    logic        busy, frame_done;

    int   total = 0;
    int   bad   = 0;
    seg_t exp_seg[$];
    int   exp_pass[$];
    int   done_count = 0;
    int   last_wall  = 0;

    always #10 CLK = ~CLK;

    draw_sequencer dut (
        .CLK        (CLK),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .note_mask  (note_mask),
        .command    (command),
        .plot       (plot),
        .note_index (note_index),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the command segments one pass must produce for a mask.
    function automatic void push_pass(input logic [14:0] m);
        int   sum;
        seg_t s;
        sum = 0;
        s = '{CLR, 4'hF, 3240}; exp_seg.push_back(s); sum += s.len;
        for (int k = 0; k < 15; k++) begin
            if (m[k]) begin
                s = '{5'(2 + k), 4'(k), 16}; exp_seg.push_back(s); sum += s.len;
            end
        end
        s = '{D1, 4'hF, 35}; exp_seg.push_back(s); sum += s.len;
        s = '{D2, 4'hF, 35}; exp_seg.push_back(s); sum += s.len;
        s = '{M0, 4'hF, 16}; exp_seg.push_back(s); sum += s.len;
        s = '{M1, 4'hF, 16}; exp_seg.push_back(s); sum += s.len;
        s = '{M2, 4'hF, 16}; exp_seg.push_back(s); sum += s.len;
        exp_pass.push_back(sum + 1);
    endfunction

    // Monitor: segments measured in enabled cycles, compared when they end.
    logic       in_run = 1'b0;
    logic [4:0] run_cmd;
    logic [3:0] run_idx;
    int         run_len, pass_cnt, plot_cnt, wall, exp_len;
    logic       prev_busy = 1'b0, prev_drawen = 1'b0, cur_draw;
    seg_t       s_exp;

    always @(negedge CLK) begin
        if (reset) begin
            in_run      = 1'b0;
            prev_busy   = 1'b0;
            prev_drawen = 1'b0;
        end else begin
            cur_draw = busy && (command != NOP);
            check("plot_lag", plot, prev_drawen);
            if (!busy) check("idle_command", command, NOP);
            if (in_run && (!cur_draw || command != run_cmd)) begin
                in_run = 1'b0;
                if (exp_seg.size() == 0) begin
                    check("extra_segment", 1, 0);
                end else begin
                    s_exp = exp_seg.pop_front();
                    check("seg_cmd", run_cmd, s_exp.cmd);
                    check("seg_idx", run_idx, s_exp.idx);
                    check("seg_len", run_len, s_exp.len);
                end
            end
            if (cur_draw && !in_run) begin
                in_run  = 1'b1;
                run_cmd = command;
                run_idx = note_index;
                run_len = 0;
            end
            if (cur_draw) begin
                check("note_index_steady", note_index, run_idx);
                if (enable) run_len++;
            end
            if (busy && !prev_busy) begin
                pass_cnt = 0;
                plot_cnt = 0;
                wall     = 0;
            end
            if (busy) begin
                wall++;
                if (enable) pass_cnt++;
                if (plot) plot_cnt++;
            end
            if (frame_done && enable) begin
                done_count++;
                last_wall = wall;
                check("done_command", command, NOP);
                if (exp_pass.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    exp_len = exp_pass.pop_front();
                    check("pass_len", pass_cnt, exp_len);
                    check("plot_cycles", plot_cnt, exp_len - 1);
                end
            end
            prev_busy   = busy;
            prev_drawen = cur_draw && enable;
        end
    end

    task automatic tick(input logic [14:0] m);
        @(posedge CLK); #1;
        note_mask  = m;
        frame_tick = 1'b1;
        @(posedge CLK); #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit rand_en);
        int n;
        n = 0;
        while (done_count < target && n < 20000) begin
            @(posedge CLK); #1;
            if (rand_en) enable = ($urandom_range(0, 7) != 0);
            n++;
        end
        enable = 1'b1;
        check("done_reached", done_count >= target, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [14:0] m;
        reset = 1'b1; enable = 1'b1; frame_tick = 1'b0; note_mask = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_command", command, NOP);
        check("rst_plot", plot, 0);
        check("rst_note_index", note_index, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);

        // Tick coincident with reset is ignored.
        frame_tick = 1'b1;
        @(posedge CLK); #1;
        frame_tick = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("tick_under_reset_busy", busy, 0);

        // Empty mask, then two notes, then all notes.
        push_pass(15'h0000); tick(15'h0000); wait_done(done_count + 1, 1'b0);
        push_pass(15'h0005); tick(15'h0005); wait_done(done_count + 1, 1'b0);
        push_pass(15'h7FFF); tick(15'h7FFF); wait_done(done_count + 1, 1'b0);

        // Two ticks mid-pass yield exactly one follow-on pass.
        dc = done_count;
        m  = 15'h1234;
        push_pass(m); tick(m);
        repeat (200) @(posedge CLK);
        push_pass(m); tick(m);
        repeat (50) @(posedge CLK);
        tick(m);
        wait_done(dc + 1, 1'b0);
        check("restart_idle_gap", busy, 0);
        @(posedge CLK); #1;
        check("restart_busy", busy, 1);
        check("restart_cmd", command, CLR);
        wait_done(dc + 2, 1'b0);
        repeat (20) @(posedge CLK);
        check("pending_done_count", done_count, dc + 2);

        // Enable gap of 10 cycles at CLEAR count 100.
        push_pass(15'h0000); tick(15'h0000);
        repeat (100) @(posedge CLK);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("gap_command", command, CLR);
            if (i > 0) check("gap_plot", plot, 0);
            @(posedge CLK); #1;
        end
        enable = 1'b1;
        wait_done(done_count + 1, 1'b0);
        check("gap_wall_len", last_wall, 3369);

        // Reset mid-pass aborts without a completion pulse.
        push_pass(15'h0000); tick(15'h0000);
        repeat (500) @(posedge CLK);
        #5;
        reset = 1'b1;
        #1;
        check("abort_command", command, NOP);
        check("abort_plot", plot, 0);
        check("abort_note_index", note_index, 4'hF);
        check("abort_busy", busy, 0);
        check("abort_frame_done", frame_done, 0);
        exp_seg.delete();
        exp_pass.delete();
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b0;
        dc = done_count;
        repeat (3000) @(posedge CLK);
        check("abort_no_done", done_count, dc);
        push_pass(15'h4001); tick(15'h4001); wait_done(done_count + 1, 1'b0);

        // Random masks, the last with random enable drops.
        for (int r = 0; r < 4; r++) begin
            m = 15'($urandom_range(0, 32767));
            push_pass(m);
            tick(m);
            wait_done(done_count + 1, r == 3);
        end

        repeat (10) @(posedge CLK);
        check("seg_queue_empty", exp_seg.size(), 0);
        check("pass_queue_empty", exp_pass.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
